// File: rtl/pwm_complementary_dt.sv
// Complementary PWM generator: period counter, shadowed settings, dead-time FSM.
// Latency: outputs follow a change in raw demand by one CLK cycle.
// No backpressure: free-running once EN=1; settings latch only at period boundaries.
module pwm_complementary_dt #(
  parameter int WIDTH    = 16,
  parameter int DT_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [WIDTH-1:0]    PERIOD,
  input  logic [WIDTH-1:0]    DUTY,
  input  logic [DT_WIDTH-1:0] DEADTIME,
  output logic                PWM_H,
  output logic                PWM_L,
  output logic                PERIOD_END
);

  // State codes carry the drive levels directly: bit1 = high side, bit0 = low
  // side, so the outputs come straight off flops and can never overlap.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_HIGH = 3'b010,
    ST_LOW  = 3'b001,
    ST_DEAD = 3'b100
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    per_s;
  logic [WIDTH-1:0]    duty_s;
  logic [DT_WIDTH-1:0] dt_s;
  logic [DT_WIDTH-1:0] dead_cnt;

  logic                raw;
  logic                wrap;
  logic                dt_zero;
  logic [WIDTH-1:0]    cnt_nxt;
  logic [WIDTH-1:0]    per_nxt;

  // Demand, period boundary and the counter/period values for the next cycle.
  always_comb begin
    raw     = (cnt < duty_s);
    wrap    = (cnt == per_s);
    dt_zero = (dt_s == '0);
    cnt_nxt = wrap ? '0 : cnt + WIDTH'(1);
    per_nxt = wrap ? PERIOD : per_s;
  end

  // Period counter and shadow registers; settings only take effect at a period boundary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      per_s  <= '0;
      duty_s <= '0;
      dt_s   <= '0;
    end else if (!EN) begin
      cnt    <= '0;
      per_s  <= PERIOD;
      duty_s <= DUTY;
      dt_s   <= DEADTIME;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) begin
        per_s  <= PERIOD;
        duty_s <= DUTY;
        dt_s   <= DEADTIME;
      end
    end
  end

  // Period-end flag is registered, so it is computed from next-cycle count and period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PERIOD_END <= 1'b0;
    end else begin
      PERIOD_END <= EN && (cnt_nxt == per_nxt);
    end
  end

  // Output FSM: every change of drive side passes through DEAD for dt_s cycles
  // unless dt_s is zero; the dead count is never restarted while in DEAD.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      state    <= ST_IDLE;
      dead_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dt_zero) begin
            state <= raw ? ST_HIGH : ST_LOW;
          end else begin
            state    <= ST_DEAD;
            dead_cnt <= dt_s;
          end
        end
        ST_HIGH: begin
          if (!raw) begin
            if (dt_zero) begin
              state <= ST_LOW;
            end else begin
              state    <= ST_DEAD;
              dead_cnt <= dt_s;
            end
          end
        end
        ST_LOW: begin
          if (raw) begin
            if (dt_zero) begin
              state <= ST_HIGH;
            end else begin
              state    <= ST_DEAD;
              dead_cnt <= dt_s;
            end
          end
        end
        ST_DEAD: begin
          // A count of 1 means this is the last dead cycle.
          if (dead_cnt <= DT_WIDTH'(1)) begin
            state    <= raw ? ST_HIGH : ST_LOW;
            dead_cnt <= '0;
          end else begin
            dead_cnt <= dead_cnt - DT_WIDTH'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          dead_cnt <= '0;
        end
      endcase
    end
  end

  assign PWM_H = state[1];
  assign PWM_L = state[0];

endmodule

// File: doc/pwm_complementary_dt.md
PWM_COMPLEMENTARY_DT -- requirements
Module: pwm_complementary_dt

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning width of the period counter, PERIOD and DUTY.
REQ-002 The block SHALL have parameter DT_WIDTH, default 8, meaning width of the dead-time counter and DEADTIME.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port EN, input, 1 bit: run enable.
REQ-006 The block SHALL have port PERIOD, input, WIDTH bits: period length minus one, in CLK cycles.
REQ-007 The block SHALL have port DUTY, input, WIDTH bits: high-side on-time in CLK cycles before dead-time.
REQ-008 The block SHALL have port DEADTIME, input, DT_WIDTH bits: dead-time cycles inserted at every output transition.
REQ-009 The block SHALL have port PWM_H, output, 1 bit: high-side drive, registered.
REQ-010 The block SHALL have port PWM_L, output, 1 bit: low-side drive, complementary to PWM_H, registered.
REQ-011 The block SHALL have port PERIOD_END, output, 1 bit: one-cycle pulse in the last cycle of each period, registered.

Function
REQ-012 The block SHALL hold shadow registers PER_S, DUTY_S and DT_S, which all load from PERIOD, DUTY and DEADTIME together: every cycle while EN=0, and in the cycle where cnt==PER_S while EN=1; they SHALL never load mid-period.
REQ-013 Counter cnt (WIDTH bits) SHALL count 0..PER_S and then wrap to 0, giving a period of PER_S+1 cycles; with PER_S=0 it SHALL remain 0 and every cycle SHALL be a period end.
REQ-014 Raw demand SHALL be raw = (cnt < DUTY_S), unsigned: DUTY_S=0 gives 0% duty, and DUTY_S > PER_S gives 100% duty.
REQ-015 The output FSM SHALL have four states, with outputs IDLE (H=0,L=0), HIGH (H=1,L=0), LOW (H=0,L=1), DEAD (H=0,L=0).
REQ-016 IDLE->DEAD SHALL occur when EN=1, loading the dead counter with DT_S.
REQ-017 HIGH->DEAD SHALL occur when raw=0, and LOW->DEAD when raw=1, each loading the dead counter with DT_S.
REQ-018 DEAD SHALL remain for exactly DT_S cycles, then go to HIGH if raw=1, else LOW; raw toggling during DEAD SHALL NOT restart the dead count.
REQ-019 When DT_S=0, HIGH<->LOW and IDLE->HIGH/LOW SHALL occur directly, skipping DEAD.
REQ-020 Demand pulses shorter than DT_S SHALL be absorbed, never producing overlap or a sub-dead-time glitch.
REQ-021 PWM_H and PWM_L SHALL never be 1 in the same cycle, under any input sequence.
REQ-022 Output latency SHALL be exactly one cycle from a raw change to the FSM reacting (outputs are driven from the state register).
REQ-023 EN=0 from any state SHALL drive the FSM to IDLE, both outputs to 0 and cnt to 0 at the next edge.
REQ-024 After EN rises, the first period SHALL start at cnt=0 using the shadow values latched while disabled.
REQ-025 PERIOD_END SHALL be 1 exactly in cycles where EN=1 and cnt==PER_S, and 0 otherwise.
REQ-026 A change to DUTY, PERIOD or DEADTIME mid-period SHALL affect only the next period.

Reset
REQ-027 RST=1 at a clock edge SHALL set cnt=0, PER_S=0, DUTY_S=0, DT_S=0, dead counter=0, FSM=IDLE, PWM_H=0, PWM_L=0 and PERIOD_END=0.
REQ-028 Reset SHALL take priority over EN and over all other events, including mid-period and mid-DEAD.
REQ-029 After RST falls, operation SHALL resume per REQ-024.

Verification
REQ-030 PERIOD=9, DUTY=5, DEADTIME=0, EN=1 -> steady state repeats H=1 for 5 cycles then L=1 for 5 cycles; PERIOD_END pulses every 10 cycles.
REQ-031 PERIOD=9, DUTY=5, DEADTIME=2 -> per period: H=1 for 3 cycles, both 0 for 2, L=1 for 3, both 0 for 2; the bench SHALL assert H&L==0 on every cycle.
REQ-032 PERIOD=9, DUTY=5, DEADTIME=0; DUTY set to 8 at cnt=3 -> current period keeps 5/5; the next period gives H=8, L=2.
REQ-033 Boundary duties -> DUTY=0 gives L held 1 and H=0; DUTY=10 (>PERIOD) gives H held 1; PERIOD=0 with DUTY=1 gives H held 1 and PERIOD_END=1 every cycle.
REQ-034 DEADTIME=4, DUTY=2, PERIOD=19 -> the 2-cycle high pulse is absorbed: H never 1, and L is low for the dead windows only.
REQ-035 RST pulsed in the middle of DEAD, and separately EN dropped during HIGH -> both outputs 0 on the next edge; after release the sequence restarts with cnt=0 and a DT_S dead window.
